// File: rtl/ysyx_22050612_isram.sv
// Instruction SRAM: single-outstanding fetch port with fixed response latency,
// plus a backdoor word-write port used to preload the program image.
module ysyx_22050612_isram #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [63:0] load_data
);

    localparam int unsigned WORDS    = 2 ** DEPTH_LOG2;
    localparam logic [63:0] SPAN     = 64'd8 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Range test on the offset rather than BASE+SPAN so nothing can wrap at 2^64.
    function automatic logic addr_in_range(input logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE;
        return (addr >= BASE) && (off < SPAN);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [63:0] addr);
        return DEPTH_LOG2'((addr - BASE) >> 3);
    endfunction

    logic [63:0]           mem_r [WORDS];
    state_t                state_r;
    state_t                state_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_s;
    logic [63:0]           addr_r;
    logic                  req_ready_r;
    logic                  resp_valid_r;
    logic                  resp_err_r;
    logic [31:0]           resp_inst_r;

    logic                  accept_s;
    logic                  rd_enter_s;
    logic [63:0]           rd_addr_s;
    logic                  rd_ok_s;
    logic [DEPTH_LOG2-1:0] rd_idx_s;
    logic [63:0]           rd_word_s;
    logic [31:0]           rd_inst_s;
    logic                  ld_ok_s;
    logic [DEPTH_LOG2-1:0] ld_idx_s;

    assign accept_s   = (state_r == ST_IDLE) && req_valid;
    assign rd_enter_s = (state_s == ST_RESP) && (state_r != ST_RESP);
    assign ld_ok_s    = load_en && (load_addr[2:0] == 3'b000) && addr_in_range(load_addr);
    assign ld_idx_s   = word_index(load_addr);

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_inst  = resp_inst_r;
    assign resp_err   = resp_err_r;

    // Next-state and latency counter decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LATENCY > 1) begin
                        state_s = ST_WAIT;
                        cnt_s   = LAT_LOAD;
                    end else begin
                        state_s = ST_RESP;
                        cnt_s   = 4'd0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_s = ST_RESP;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Read path; with LATENCY=1 the array is read from the live request address.
    // A backdoor write landing on the RESP-entry edge is forwarded into the response.
    always_comb begin
        rd_addr_s = addr_r;
        rd_word_s = 64'd0;
        rd_inst_s = 32'd0;
        if (state_r == ST_IDLE) begin
            rd_addr_s = req_addr;
        end else begin
            rd_addr_s = addr_r;
        end
        rd_ok_s  = (rd_addr_s[1:0] == 2'b00) && addr_in_range(rd_addr_s);
        rd_idx_s = word_index(rd_addr_s);
        if (ld_ok_s && (ld_idx_s == rd_idx_s)) begin
            rd_word_s = load_data;
        end else begin
            rd_word_s = mem_r[rd_idx_s];
        end
        if (!rd_ok_s) begin
            rd_inst_s = 32'd0;
        end else if (rd_addr_s[2]) begin
            rd_inst_s = rd_word_s[63:32];
        end else begin
            rd_inst_s = rd_word_s[31:0];
        end
    end

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_ok_s) begin
            mem_r[ld_idx_s] <= load_data;
        end
    end

    // Control state, captured address and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            addr_r       <= 64'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_inst_r  <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            req_ready_r  <= (state_s == ST_IDLE);
            resp_valid_r <= (state_s == ST_RESP);
            if (accept_s) begin
                addr_r <= req_addr;
            end
            if (rd_enter_s) begin
                resp_inst_r <= rd_inst_s;
                resp_err_r  <= ~rd_ok_s;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_isram.sv
// Scoreboard bench: channel 0 runs LATENCY=2, channel 1 runs LATENCY=1.
module tb_ysyx_22050612_isram;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst, req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
    logic [63:0] req_addr [2];
    logic [63:0] load_addr [2];
    logic [63:0] load_data [2];
    logic [31:0] resp_inst [2];

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [1:0] in_resp = 2'b00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22050612_isram #(.LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_inst(resp_inst[0]), .resp_err(resp_err[0]), .load_en(load_en[0]),
        .load_addr(load_addr[0]), .load_data(load_data[0])
    );

    ysyx_22050612_isram #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_inst(resp_inst[1]), .resp_err(resp_err[1]), .load_en(load_en[1]),
        .load_addr(load_addr[1]), .load_data(load_data[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: latency is the edge at which resp_valid is first sampled high, minus the accept edge.
    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (rst[ch]) begin
                in_resp[ch] = 1'b0;
                acc_q.delete();
            end else begin
                if (resp_valid[ch]) begin
                    if (!in_resp[ch]) begin
                        in_resp[ch] = 1'b1;
                        if (exp_q.size() == 0 || acc_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_resp ch=%0d actual inst=%h err=%b required no response",
                                     ch, resp_inst[ch], resp_err[ch]);
                        end else begin
                            chk("resp_latency", 64'(cyc + 1 - acc_q[0]), (ch == 0) ? 64'd2 : 64'd1);
                            chk("resp_inst", 64'(resp_inst[ch]), 64'(exp_q[0].inst));
                            chk("resp_err", 64'(resp_err[ch]), 64'(exp_q[0].err));
                        end
                    end else if (exp_q.size() != 0) begin
                        chk("resp_inst_stable", 64'(resp_inst[ch]), 64'(exp_q[0].inst));
                    end
                    chk("req_ready_in_resp", 64'(req_ready[ch]), 64'd0);
                    if (resp_ready[ch]) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        if (acc_q.size() != 0) void'(acc_q.pop_front());
                        in_resp[ch] = 1'b0;
                    end
                end
                if (req_valid[ch] && req_ready[ch]) acc_q.push_back(cyc + 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [63:0] addr, input logic [63:0] data);
        load_en[ch] = 1'b1;
        load_addr[ch] = addr;
        load_data[ch] = data;
        step();
        load_en[ch] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic issue(input int ch, input logic [63:0] addr);
        for (int i = 0; i < 40 && !req_ready[ch]; i++) step();
        chk("req_ready_idle", 64'(req_ready[ch]), 64'd1);
        req_valid[ch] = 1'b1;
        req_addr[ch] = addr;
        step();
        req_valid[ch] = 1'b0;
    endtask

    task automatic fetch(input int ch, input logic [63:0] addr, input logic [31:0] inst, input logic err);
        exp_q.push_back('{inst: inst, err: err});
        issue(ch, addr);
        wait_drain();
    endtask

    logic [63:0] b2b_words [4] = '{64'h10000001_10000000, 64'h10000003_10000002,
                                   64'h10000005_10000004, 64'h10000007_10000006};
    logic [31:0] b2b_inst [8] = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                                  32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 2'b11; req_valid = 2'b00; resp_ready = 2'b11; load_en = 2'b00;
        for (int c = 0; c < 2; c++) begin
            req_addr[c] = 64'd0; load_addr[c] = 64'd0; load_data[c] = 64'd0;
        end
        step();
        step();
        for (int c = 0; c < 2; c++) begin
            chk("rst_req_ready", 64'(req_ready[c]), 64'd1);
            chk("rst_resp_valid", 64'(resp_valid[c]), 64'd0);
            chk("rst_resp_inst", 64'(resp_inst[c]), 64'd0);
            chk("rst_resp_err", 64'(resp_err[c]), 64'd0);
        end
        rst = 2'b00;
        step();

        // Basic fetch, both halves of word 0
        load(0, 64'h8000_0000, 64'h00100093_00000513);
        fetch(0, 64'h8000_0000, 32'h00000513, 1'b0);
        fetch(0, 64'h8000_0004, 32'h00100093, 1'b0);

        // Out-of-range and misaligned backdoor writes must be dropped
        load(0, 64'h8000_8000, 64'hFFFFFFFF_FFFFFFFF);
        load(0, 64'h8000_0004, 64'hDEADBEEF_DEADBEEF);
        fetch(0, 64'h8000_0000, 32'h00000513, 1'b0);

        // Last in-range word
        load(0, 64'h8000_7FF8, 64'hCAFEBABE_12345678);
        fetch(0, 64'h8000_7FFC, 32'hCAFEBABE, 1'b0);
        fetch(0, 64'h8000_7FF8, 32'h12345678, 1'b0);

        // Faults
        fetch(0, 64'h7FFF_FFFC, 32'h0, 1'b1);
        fetch(0, 64'h8000_0002, 32'h0, 1'b1);
        fetch(0, 64'h8000_8000, 32'h0, 1'b1);
        fetch(0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1'b1);

        // Backpressure
        load(0, 64'h8000_0008, 64'h11112222_33334444);
        resp_ready[0] = 1'b0;
        exp_q.push_back('{inst: 32'h33334444, err: 1'b0});
        issue(0, 64'h8000_0008);
        for (int i = 0; i < 20 && !resp_valid[0]; i++) step();
        chk("bp_valid", 64'(resp_valid[0]), 64'd1);
        for (int i = 0; i < 5; i++) step();
        chk("bp_valid_held", 64'(resp_valid[0]), 64'd1);
        chk("bp_ready_low", 64'(req_ready[0]), 64'd0);
        resp_ready[0] = 1'b1;
        step();
        chk("bp_idle_ready", 64'(req_ready[0]), 64'd1);
        chk("bp_idle_valid", 64'(resp_valid[0]), 64'd0);
        chk("bp_consumed", 64'(exp_q.size()), 64'd0);

        // Write during WAIT is visible
        load(0, 64'h8000_0010, 64'hAAAA0001_AAAA0000);
        exp_q.push_back('{inst: 32'hBBBB0000, err: 1'b0});
        issue(0, 64'h8000_0010);
        load(0, 64'h8000_0010, 64'hBBBB0001_BBBB0000);
        wait_drain();

        // Write during RESP is not visible, but does land in the array
        load(0, 64'h8000_0018, 64'hCCCC0001_CCCC0000);
        resp_ready[0] = 1'b0;
        exp_q.push_back('{inst: 32'hCCCC0000, err: 1'b0});
        issue(0, 64'h8000_0018);
        step();
        chk("race_in_resp", 64'(resp_valid[0]), 64'd1);
        load(0, 64'h8000_0018, 64'hDDDD0001_DDDD0000);
        resp_ready[0] = 1'b1;
        wait_drain();
        fetch(0, 64'h8000_0018, 32'hDDDD0000, 1'b0);

        // Reset in WAIT aborts the fetch; a coincident backdoor write still lands
        req_valid[0] = 1'b1;
        req_addr[0] = 64'h8000_0020;
        step();
        req_valid[0] = 1'b0;
        rst[0] = 1'b1;
        load(0, 64'h8000_0028, 64'h5555AAAA_12121212);
        rst[0] = 1'b0;
        chk("abort_req_ready", 64'(req_ready[0]), 64'd1);
        chk("abort_resp_valid", 64'(resp_valid[0]), 64'd0);
        chk("abort_resp_inst", 64'(resp_inst[0]), 64'd0);
        for (int i = 0; i < 10; i++) step();
        chk("abort_no_resp", 64'(resp_valid[0]), 64'd0);
        fetch(0, 64'h8000_002C, 32'h5555AAAA, 1'b0);

        // LATENCY=1 back-to-back sequential stream
        for (int w = 0; w < 4; w++) load(1, 64'h8000_0000 + 64'(8 * w), b2b_words[w]);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready", 64'(req_ready[1]), 64'd1);
            req_addr[1] = 64'h8000_0000 + 64'(4 * i);
            exp_q.push_back('{inst: b2b_inst[i], err: 1'b0});
            step();
            step();
        end
        req_valid[1] = 1'b0;
        wait_drain();
        fetch(1, 64'h8000_0001, 32'h0, 1'b1);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_isram.md
YSYX_22050612_ISRAM -- requirements
Module: ysyx_22050612_isram

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH_LOG2, 12, log2 of the number of 64-bit words stored.
- BASE, 64'h80000000, byte address of word 0.
- LATENCY, 2, cycles from request accept to response valid, legal range 1..15.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block can accept a fetch request.
- req_addr  in  64  fetch byte address (the PC).
- resp_valid  out  1  fetch response present.
- resp_ready  in  1  requester accepts the response.
- resp_inst  out  32  fetched instruction.
- resp_err  out  1  access fault on this response.
- load_en  in  1  backdoor word write (image preload).
- load_addr  in  64  backdoor byte address, 8-byte aligned.
- load_data  in  64  backdoor write data.

Function
REQ-003 The block SHALL store 2^DEPTH_LOG2 64-bit words; word index = (addr - BASE) >> 3.
REQ-004 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_addr SHALL be captured on that edge.
REQ-005 The FSM SHALL have three states:
- IDLE: req_ready=1, resp_valid=0.
- WAIT: req_ready=0, resp_valid=0, latency counter running.
- RESP: req_ready=0, resp_valid=1.
REQ-006 IDLE SHALL go to WAIT on accept when LATENCY>1, and directly to RESP when LATENCY=1.
REQ-007 On entering WAIT the counter SHALL load LATENCY-1, then decrement once per cycle; WAIT SHALL go to RESP on the edge where the counter equals 1.
REQ-008 resp_valid SHALL therefore first assert exactly LATENCY cycles after the accept edge.
REQ-009 RESP SHALL hold resp_inst and resp_err stable until resp_valid && resp_ready, then return to IDLE; there SHALL be no request/response overlap (at most one outstanding fetch).
REQ-010 resp_inst SHALL be bits [63:32] of the addressed word when captured addr[2]=1, else bits [31:0].
REQ-011 resp_err SHALL be 1, with resp_inst=32'h00000000, when the captured address has addr[1:0]!=0, is below BASE, or is at or above BASE + 8*2^DEPTH_LOG2; out-of-range addresses SHALL NOT alias into the array.
REQ-012 The word SHALL be read at RESP entry, so a load_en write to the same word before RESP entry SHALL be visible in the response; a write after RESP entry SHALL NOT change the held response.
REQ-013 load_en SHALL write load_data to the word at load_addr on the clock edge in any FSM state; out-of-range or misaligned load_addr SHALL be ignored.
REQ-014 Address arithmetic SHALL be done in 64-bit unsigned arithmetic, with no wrap-around at 2^64 producing an in-range hit.
REQ-015 req_addr and req_valid SHALL be ignored in WAIT and RESP.

Reset
REQ-016 While rst=1 at a rising edge, the FSM SHALL go to IDLE, the counter SHALL clear, and outputs SHALL be req_ready=1, resp_valid=0, resp_inst=0, resp_err=0.
REQ-017 Reset SHALL abort an in-flight fetch in WAIT or RESP with no response delivered.
REQ-018 Array contents SHALL NOT be cleared by reset; a load_en write coincident with rst=1 SHALL still be performed.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Basic fetch, LATENCY=2: preload word 0 = 64'h00100093_00000513; request 0x80000000 -> resp_valid 2 cycles after accept, inst=32'h00000513, err=0; request 0x80000004 -> inst=32'h00100093.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid stays 1, inst stable, req_ready=0 throughout; returns to IDLE the cycle after resp_ready=1.
- Faults: requests 0x7FFFFFFC, 0x80000002 and BASE+8*2^DEPTH_LOG2 -> err=1, inst=0, with the same latency as a good fetch.
- LATENCY=1 back-to-back: keep req_valid=1 and resp_ready=1 over a sequential PC stream -> one response every 2 cycles, in order, with correct data.
- Preload race: load_en to the target word during WAIT -> response returns the new data; load_en during RESP -> response keeps the old data.
- Reset mid-fetch: assert rst in WAIT -> next cycle req_ready=1, resp_valid=0, and no response is ever delivered for the aborted fetch.
